// File: rtl/rpn_evaluator.sv
// rpn_evaluator: walks a token queue in reverse Polish order and evaluates
// it on an operand stack with signed Q8.8 arithmetic. The queue is an external
// read-only memory with one cycle of read latency. Each token costs a FETCH
// cycle and an EXEC cycle, and POW spends a further n cycles in a
// multiply loop.
module rpn_evaluator #(
    parameter int STACK_DEPTH      = 16,
    parameter int QUEUE_ADDR_WIDTH = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [15:0]                 x,
    input  logic [QUEUE_ADDR_WIDTH:0]   queue_len,
    output logic [QUEUE_ADDR_WIDTH-1:0] rd_addr,
    input  logic [16:0]                 rd_data,
    output logic                        busy,
    output logic                        done,
    output logic [15:0]                 result,
    output logic [2:0]                  error
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int SA_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int IX_W = QUEUE_ADDR_WIDTH + 1;

    localparam logic [2:0]  OP_PLUS = 3'd0;
    localparam logic [2:0]  OP_SUB  = 3'd1;
    localparam logic [2:0]  OP_MUL  = 3'd2;
    localparam logic [2:0]  OP_DIV  = 3'd3;
    localparam logic [2:0]  OP_POW  = 3'd4;
    localparam logic [2:0]  OP_VAR  = 3'd6;
    localparam logic [15:0] FX_ONE  = 16'h0100;

    typedef enum logic [2:0] {
        IDLE, FETCH, EXEC, POW_LOOP, CHECK, DONE
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_UNDERFLOW  = 3'd1,
        ERR_OVERFLOW   = 3'd2,
        ERR_DIV_ZERO   = 3'd3,
        ERR_DEPTH      = 3'd4,
        ERR_ILLEGAL_OP = 3'd5,
        ERR_NEG_EXP    = 3'd6,
        ERR_EMPTY      = 3'd7
    } err_e;

    // Q8.8 multiply: full signed product, arithmetic shift right by 8, low 16 bits.
    function automatic logic [15:0] fx_mul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] prod;
        prod = $signed(a) * $signed(b);
        return prod[23:8];
    endfunction

    // Q8.8 divide: dividend pre-scaled by 256, signed quotient truncated toward zero.
    // A zero divisor is replaced by 1 so the unused quotient never goes to X;
    // the caller flags that case as an error and never consumes the value.
    function automatic logic [15:0] fx_div(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] num;
        logic signed [31:0] den;
        logic signed [31:0] quo;
        num = {{8{a[15]}}, a, 8'h00};
        den = (b == 16'h0000) ? 32'sd1 : {{16{b[15]}}, b};
        quo = num / den;
        return quo[15:0];
    endfunction

    state_e               state_q, state_d;
    err_e                 error_q, error_d;
    logic [15:0]          x_q, x_d;
    logic [IX_W-1:0]      len_q, len_d;
    logic [IX_W-1:0]      idx_q, idx_d;
    logic [SP_W-1:0]      sp_q, sp_d;
    logic [15:0]          acc_q, acc_d;
    logic [15:0]          base_q, base_d;
    logic [6:0]           cnt_q, cnt_d;
    logic [15:0]          result_q, result_d;

    logic [15:0]          stack_mem [STACK_DEPTH];
    logic                 stk_we;
    logic [SA_W-1:0]      stk_waddr;
    logic [15:0]          stk_wdata;

    logic [SA_W-1:0]      push_idx, top_idx, nxt_idx;
    logic [15:0]          op_a, op_b, alu_y, acc_next;
    logic [2:0]           opcode;
    logic                 stack_full, under_two;
    logic [IX_W-1:0]      idx_inc;
    logic                 last_tok;
    err_e                 err_code;
    logic                 adv;

    // Stack addressing: top is b, the entry below it is a.
    assign push_idx   = SA_W'(sp_q);
    assign top_idx    = SA_W'(sp_q - SP_W'(1));
    assign nxt_idx    = SA_W'(sp_q - SP_W'(2));
    assign op_b       = stack_mem[top_idx];
    assign op_a       = stack_mem[nxt_idx];
    assign opcode     = rd_data[2:0];
    assign stack_full = (sp_q == SP_W'(STACK_DEPTH));
    assign under_two  = (sp_q < SP_W'(2));
    assign idx_inc    = idx_q + 1'b1;
    assign last_tok   = (idx_inc == len_q);
    assign acc_next   = fx_mul(acc_q, base_q);

    assign rd_addr = idx_q[QUEUE_ADDR_WIDTH-1:0];
    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = (state_q == DONE);
    assign result  = result_q;
    assign error   = error_q;

    // Binary-operator datapath for the four single-cycle operators.
    always_comb begin
        unique case (opcode)
            OP_PLUS: alu_y = op_a + op_b;
            OP_SUB:  alu_y = op_a - op_b;
            OP_MUL:  alu_y = fx_mul(op_a, op_b);
            OP_DIV:  alu_y = fx_div(op_a, op_b);
            default: alu_y = 16'h0000;
        endcase
    end

    // Next-state logic: sequencing, stack updates and error detection.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        error_d   = error_q;
        x_d       = x_q;
        len_d     = len_q;
        idx_d     = idx_q;
        sp_d      = sp_q;
        acc_d     = acc_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        stk_we    = 1'b0;
        stk_waddr = push_idx;
        stk_wdata = rd_data[15:0];
        err_code  = ERR_NONE;
        adv       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d      = x;
                    len_d    = queue_len;
                    idx_d    = '0;
                    sp_d     = '0;
                    error_d  = ERR_NONE;
                    result_d = 16'h0000;
                    if (queue_len == '0) begin
                        error_d = ERR_EMPTY;
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            FETCH: state_d = EXEC;

            EXEC: begin
                if (!rd_data[16] || (opcode == OP_VAR)) begin
                    // Number literal or the latched variable: a push.
                    if (stack_full) begin
                        err_code = ERR_OVERFLOW;
                    end else begin
                        stk_we    = 1'b1;
                        stk_waddr = push_idx;
                        stk_wdata = rd_data[16] ? x_q : rd_data[15:0];
                        sp_d      = sp_q + 1'b1;
                        adv       = 1'b1;
                    end
                end else begin
                    unique case (opcode)
                        OP_PLUS, OP_SUB, OP_MUL, OP_DIV: begin
                            if (under_two) begin
                                err_code = ERR_UNDERFLOW;
                            end else if ((opcode == OP_DIV) && (op_b == 16'h0000)) begin
                                err_code = ERR_DIV_ZERO;
                            end else begin
                                stk_we    = 1'b1;
                                stk_waddr = nxt_idx;
                                stk_wdata = alu_y;
                                sp_d      = sp_q - 1'b1;
                                adv       = 1'b1;
                            end
                        end
                        OP_POW: begin
                            if (under_two) begin
                                err_code = ERR_UNDERFLOW;
                            end else if (op_b[15]) begin
                                err_code = ERR_NEG_EXP;
                            end else if (op_b[14:8] == 7'd0) begin
                                // a^0 finishes here without entering the loop.
                                stk_we    = 1'b1;
                                stk_waddr = nxt_idx;
                                stk_wdata = FX_ONE;
                                sp_d      = sp_q - 1'b1;
                                adv       = 1'b1;
                            end else begin
                                // Pop b now; a's slot is overwritten when the loop ends.
                                acc_d   = FX_ONE;
                                base_d  = op_a;
                                cnt_d   = op_b[14:8];
                                sp_d    = sp_q - 1'b1;
                                state_d = POW_LOOP;
                            end
                        end
                        default: err_code = ERR_ILLEGAL_OP;
                    endcase
                end
            end

            POW_LOOP: begin
                acc_d = acc_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 7'd1) begin
                    stk_we    = 1'b1;
                    stk_waddr = top_idx;
                    stk_wdata = acc_next;
                    adv       = 1'b1;
                end
            end

            CHECK: begin
                if (sp_q == SP_W'(1)) begin
                    result_d = op_b;
                    error_d  = ERR_NONE;
                end else begin
                    result_d = 16'h0000;
                    error_d  = ERR_DEPTH;
                end
                state_d = DONE;
            end

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase

        // A token error abandons the queue; otherwise a finished token moves the index on.
        if (err_code != ERR_NONE) begin
            error_d  = err_code;
            result_d = 16'h0000;
            state_d  = DONE;
        end else if (adv) begin
            idx_d   = idx_inc;
            state_d = last_tok ? CHECK : FETCH;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= IDLE;
            error_q  <= ERR_NONE;
            x_q      <= 16'h0000;
            len_q    <= '0;
            idx_q    <= '0;
            sp_q     <= '0;
            acc_q    <= 16'h0000;
            base_q   <= 16'h0000;
            cnt_q    <= 7'd0;
            result_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            error_q  <= error_d;
            x_q      <= x_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            sp_q     <= sp_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Operand stack storage.
    always_ff @(posedge clk) begin
        // NOTE: the stack array has no reset; clearing the stack pointer is what
        // empties it, so the storage can map onto plain RAM.
        if (stk_we) begin
            stack_mem[stk_waddr] <= stk_wdata;
        end
    end

endmodule

// File: tb/tb_rpn_evaluator.sv
// tb_rpn_evaluator: table-driven directed vectors, hand-written corner
// sequences (full stack, ignored start, reset during the power loop) and
// randomized queues compared against a queue-based reference model.
module tb_rpn_evaluator;

    localparam int QAW    = 6;
    localparam int BUDGET = 5000;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [15:0]    x;
    logic [QAW:0]   queue_len;
    logic [QAW-1:0] rd_addr;
    logic [16:0]    rd_data;
    logic           busy;
    logic           done;
    logic [15:0]    result;
    logic [2:0]     error;

    logic [16:0]    qmem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Token queue with one cycle of read latency.
    always @(posedge clk) rd_data <= qmem[rd_addr];

    rpn_evaluator #(.STACK_DEPTH(16), .QUEUE_ADDR_WIDTH(QAW)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .queue_len(queue_len),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .result(result), .error(error)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_mul(input logic signed [15:0] a, input logic signed [15:0] b);
        int p;
        p = int'(a) * int'(b);
        p = p >>> 8;
        return p[15:0];
    endfunction

    function automatic logic [15:0] m_div(input logic signed [15:0] a, input logic signed [15:0] b);
        int q;
        q = (int'(a) * 256) / int'(b);
        return q[15:0];
    endfunction

    // Evaluates qmem[0..len-1]; lat is the cycle of done, counting the
    // start-accept cycle as cycle 0.
    function automatic void model(input logic [15:0] xv, input int len,
                                  output logic [15:0] res, output logic [2:0] err,
                                  output int lat);
        logic signed [15:0] stk[$];
        logic signed [15:0] a, b, acc;
        logic [16:0] t;
        int extra, n;
        res = 16'h0000; err = 3'd0; extra = 0; lat = 0;
        if (len == 0) begin
            err = 3'd7; lat = 1; return;
        end
        for (int i = 0; i < len; i++) begin
            t = qmem[i];
            if (!t[16] || t[2:0] == 3'd6) begin
                if (stk.size() == 16) begin
                    err = 3'd2; lat = 2*i + 3 + extra; return;
                end
                stk.push_back(t[16] ? xv : t[15:0]);
            end else if (t[2:0] == 3'd5 || t[2:0] == 3'd7) begin
                err = 3'd5; lat = 2*i + 3 + extra; return;
            end else begin
                if (stk.size() < 2) begin
                    err = 3'd1; lat = 2*i + 3 + extra; return;
                end
                b = stk.pop_back();
                a = stk.pop_back();
                case (t[2:0])
                    3'd0: stk.push_back(a + b);
                    3'd1: stk.push_back(a - b);
                    3'd2: stk.push_back(m_mul(a, b));
                    3'd3: begin
                        if (b == 0) begin
                            err = 3'd3; lat = 2*i + 3 + extra; return;
                        end
                        stk.push_back(m_div(a, b));
                    end
                    default: begin
                        n = int'(b) >>> 8;
                        if (n < 0) begin
                            err = 3'd6; lat = 2*i + 3 + extra; return;
                        end
                        acc = 16'sh0100;
                        repeat (n) acc = m_mul(acc, a);
                        extra += n;
                        stk.push_back(acc);
                    end
                endcase
            end
        end
        if (stk.size() == 1) res = stk[0];
        else err = 3'd4;
        lat = 2*len + 2 + extra;
    endfunction

    // ---------------- drivers ----------------
    task automatic start_eval(input logic [15:0] xv, input int len);
        @(negedge clk);
        x = xv; queue_len = (QAW+1)'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs to prove they were latched at acceptance.
        x = 16'($urandom); queue_len = (QAW+1)'($urandom);
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic finish_case(input string nm, input logic [15:0] er, input logic [2:0] ee,
                               input int el, input int lat);
        check({nm, "_done"}, done, 1);
        check({nm, "_result"}, result, er);
        check({nm, "_error"}, error, ee);
        check({nm, "_latency"}, lat, el);
        check({nm, "_busy_at_done"}, busy, 0);
        if (!done) pulse_reset();
        @(posedge clk); #1;
        check({nm, "_done_one_cycle"}, done, 0);
    endtask

    task automatic run_case(input string nm, input logic [15:0] xv, input int len,
                            input logic [15:0] er, input logic [2:0] ee, input int el);
        int lat;
        start_eval(xv, len);
        if (len > 0) check({nm, "_busy"}, busy, 1);
        wait_done(1, lat);
        finish_case(nm, er, ee, el, lat);
    endtask

    function automatic logic [16:0] rand_tok();
        int r;
        logic [7:0] ip, fr;
        r  = $urandom_range(0, 99);
        ip = 8'($urandom_range(0, 6)) - 8'd2;
        fr = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
        if (r < 40) return {1'b0, ip, fr};
        if (r < 48) return {1'b0, 16'($urandom)};
        if (r < 58) return {1'b1, 13'($urandom), 3'd6};
        if (r < 68) return {1'b1, 13'($urandom), 3'd0};
        if (r < 76) return {1'b1, 13'($urandom), 3'd1};
        if (r < 84) return {1'b1, 13'($urandom), 3'd2};
        if (r < 90) return {1'b1, 13'($urandom), 3'd3};
        if (r < 96) return {1'b1, 13'($urandom), 3'd4};
        if (r < 98) return {1'b1, 13'($urandom), 3'd5};
        return {1'b1, 13'($urandom), 3'd7};
    endfunction

    typedef struct {
        string       name;
        logic [15:0] xv;
        int          len;
        logic [16:0] t0, t1, t2;
        logic [15:0] exp_res;
        logic [2:0]  exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic [15:0] xv, input int len,
                           input logic [16:0] t0, input logic [16:0] t1, input logic [16:0] t2,
                           input logic [15:0] er, input logic [2:0] ee, input int el);
        vec_t v;
        v.name = nm; v.xv = xv; v.len = len; v.t0 = t0; v.t1 = t1; v.t2 = t2;
        v.exp_res = er; v.exp_err = ee; v.exp_lat = el;
        vecs.push_back(v);
    endtask

    task automatic load3(input logic [16:0] t0, input logic [16:0] t1, input logic [16:0] t2);
        for (int i = 0; i < 64; i++) qmem[i] = 17'h10007;
        qmem[0] = t0; qmem[1] = t1; qmem[2] = t2;
    endtask

    initial begin
        int lat, dcount, len;
        logic [15:0] er, xv;
        logic [2:0]  ee;
        int el;

        //        name        x        len tok0      tok1      tok2      result   err lat
        add_vec("add",       16'h0000, 3, 17'h00200, 17'h00300, 17'h10000, 16'h0500, 0, 8);
        add_vec("var_mul",   16'h0180, 3, 17'h10006, 17'h10006, 17'h10002, 16'h0240, 0, 8);
        add_vec("pow3",      16'h0000, 3, 17'h00200, 17'h00300, 17'h10004, 16'h0800, 0, 11);
        add_vec("div_zero",  16'h0000, 3, 17'h00100, 17'h00000, 17'h10003, 16'h0000, 3, 7);
        add_vec("underflow", 16'h0000, 1, 17'h10000, 17'h10007, 17'h10007, 16'h0000, 1, 3);
        add_vec("underfl_1", 16'h0000, 2, 17'h00100, 17'h10001, 17'h10007, 16'h0000, 1, 5);
        add_vec("depth2",    16'h0000, 2, 17'h00100, 17'h00200, 17'h10007, 16'h0000, 4, 6);
        add_vec("empty",     16'h0000, 0, 17'h10007, 17'h10007, 17'h10007, 16'h0000, 7, 1);
        add_vec("pow0",      16'h0000, 3, 17'h00200, 17'h00000, 17'h10004, 16'h0100, 0, 8);
        add_vec("neg_exp",   16'h0000, 3, 17'h00200, 17'h0FF00, 17'h10004, 16'h0000, 6, 7);
        add_vec("illegal5",  16'h0000, 1, 17'h10005, 17'h10007, 17'h10007, 16'h0000, 5, 3);
        add_vec("illegal7",  16'h0000, 1, 17'h10007, 17'h10007, 17'h10007, 16'h0000, 5, 3);
        add_vec("sub_neg",   16'h0000, 3, 17'h00200, 17'h00300, 17'h10001, 16'hFF00, 0, 8);
        add_vec("div_neg",   16'h0000, 3, 17'h0FD00, 17'h00200, 17'h10003, 16'hFE80, 0, 8);
        add_vec("div_trunc", 16'h0000, 3, 17'h0FFFF, 17'h00300, 17'h10003, 16'h0000, 0, 8);
        add_vec("mul_neg",   16'h0000, 3, 17'h0FE80, 17'h00200, 17'h10002, 16'hFD00, 0, 8);
        add_vec("mul_floor", 16'h0000, 3, 17'h0FFFF, 17'h00001, 17'h10002, 16'hFFFF, 0, 8);
        add_vec("add_wrap",  16'h0000, 3, 17'h07F00, 17'h00100, 17'h10000, 16'h8000, 0, 8);
        add_vec("single",    16'h0000, 1, 17'h01234, 17'h10007, 17'h10007, 16'h1234, 0, 4);
        add_vec("pow_frac",  16'h0000, 3, 17'h0FE00, 17'h00280, 17'h10004, 16'h0400, 0, 10);

        rst = 1'b1; start = 1'b0; x = '0; queue_len = '0;
        for (int i = 0; i < 64; i++) qmem[i] = 17'h10007;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_error", error, 0);
        check("reset_rd_addr", rd_addr, 0);
        @(negedge clk); rst = 1'b0;

        // Directed table.
        foreach (vecs[k]) begin
            load3(vecs[k].t0, vecs[k].t1, vecs[k].t2);
            run_case(vecs[k].name, vecs[k].xv, vecs[k].len,
                     vecs[k].exp_res, vecs[k].exp_err, vecs[k].exp_lat);
        end

        // Full stack: 16 pushes then 15 adds is legal.
        for (int i = 0; i < 64; i++) qmem[i] = 17'h10007;
        for (int i = 0; i < 16; i++) qmem[i] = 17'h00100;
        for (int i = 16; i < 31; i++) qmem[i] = 17'h10000;
        run_case("full_stack", 16'h0000, 31, 16'h1000, 3'd0, 64);

        // A 17th push overflows at its EXEC.
        for (int i = 0; i < 64; i++) qmem[i] = 17'h00100 + 17'(i);
        run_case("overflow17", 16'h0000, 20, 16'h0000, 3'd2, 35);

        // start while busy is ignored.
        load3(17'h00200, 17'h00300, 17'h10004);
        start_eval(16'h0000, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b1; queue_len = '0; x = 16'h7777;
        @(posedge clk); #1; start = 1'b0;
        wait_done(4, lat);
        finish_case("start_busy", 16'h0800, 3'd0, 11, lat);

        // Reset in the middle of a long power loop.
        load3(17'h00200, 17'h06400, 17'h10004);
        start_eval(16'h0000, 3);
        for (int c = 1; c < 12; c++) begin
            @(posedge clk); #1;
        end
        check("pow_loop_busy", busy, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_rd_addr", rd_addr, 0);
        @(negedge clk); rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        check("no_done_after_abort", dcount, 0);
        load3(17'h00200, 17'h00300, 17'h10000);
        run_case("after_rst_add", 16'h0000, 3, 16'h0500, 3'd0, 8);
        load3(17'h10006, 17'h10006, 17'h10002);
        run_case("fresh_x", 16'h0200, 3, 16'h0400, 3'd0, 8);

        // Randomized queues against the reference model.
        for (int k = 0; k < 300; k++) begin
            len = $urandom_range(0, 24);
            for (int i = 0; i < 64; i++) qmem[i] = i < len ? rand_tok() : 17'($urandom);
            xv = ($urandom_range(0, 1) == 1) ? 16'($urandom) : {8'($urandom_range(0, 3)), 8'($urandom)};
            model(xv, len, er, ee, el);
            run_case($sformatf("rnd%0d", k), xv, len, er, ee, el);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
